// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL supervisor.
//   pll_state_e : supervisor FSM states
//   PS_CNT_W    : width of the phase-shift step count
//   RETRY_W     : width of the lock-timeout retry counter
//   LOSS_W      : width of the saturating lock-loss counter
package pll_pkg;

  localparam int unsigned PS_CNT_W = 8;
  localparam int unsigned RETRY_W  = 4;
  localparam int unsigned LOSS_W   = 8;

  typedef enum logic [2:0] {
    StRstPll,
    StWaitLock,
    StRun,
    StSetup,
    StPulse,
    StGap,
    StSettle,
    StFault
  } pll_state_e;

  // States in which the PLL is considered locked and downstream logic runs.
  function automatic logic is_active(pll_state_e s);
    return (s == StRun) || (s == StSetup) || (s == StPulse) || (s == StGap) || (s == StSettle);
  endfunction

  // States in which a phase-shift request is in flight.
  function automatic logic is_shift(pll_state_e s);
    return (s == StSetup) || (s == StPulse) || (s == StGap) || (s == StSettle);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// PLL supervisor: drives PLL reset, qualifies LOCK, gates the downstream reset and serialises
// dynamic phase-shift requests onto PHASESEL/PHASEDIR/PHASESTEP.
//   clk, rst_n          : board clock, asynchronous active-low reset
//   pll_locked_i        : PLL LOCK (asynchronous)
//   pll_rst_o           : PLL RST, active high
//   pll_phasesel_o/dir_o: phase-shift select / direction
//   pll_phasestep_o     : idle high, active-low step pulse
//   sys_rst_n_o         : downstream reset, released once lock is qualified
//   ps_valid_i/ready_o  : phase-shift request handshake (ps_sel_i, ps_dir_i, ps_count_i)
//   ps_done_o/abort_o   : 1-cycle completion / lock-loss abort pulses
//   fault_o             : sticky lock failure after exhausting retries
//   retry_cnt_o         : consecutive lock-timeout retries
//   loss_cnt_o          : saturating count of lock-loss events
module pll_supervisor
  import pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STEP_LOW      = 2,
  parameter int unsigned STEP_GAP      = 4,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked_i,
  output logic                pll_rst_o,
  output logic [1:0]          pll_phasesel_o,
  output logic                pll_phasedir_o,
  output logic                pll_phasestep_o,
  output logic                sys_rst_n_o,
  input  logic                ps_valid_i,
  output logic                ps_ready_o,
  input  logic [1:0]          ps_sel_i,
  input  logic                ps_dir_i,
  input  logic [PS_CNT_W-1:0] ps_count_i,
  output logic                ps_done_o,
  output logic                ps_abort_o,
  output logic                fault_o,
  output logic [RETRY_W-1:0]  retry_cnt_o,
  output logic [LOSS_W-1:0]   loss_cnt_o
);

  // One phase timer serves every timed state, so it is sized for the longest interval.
  localparam int unsigned TmrMax = max_u(max_u(max_u(RST_CYCLES, LOCK_TIMEOUT),
                                               max_u(SETUP_CYCLES, STEP_LOW)),
                                         max_u(STEP_GAP, SETTLE_CYCLES));
  localparam int unsigned TmrW    = $clog2(TmrMax + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE + 1);

  localparam logic [TmrW-1:0]    RstLast     = TmrW'(RST_CYCLES - 1);
  localparam logic [TmrW-1:0]    TimeoutLast = TmrW'(LOCK_TIMEOUT - 1);
  localparam logic [TmrW-1:0]    SetupLast   = TmrW'(SETUP_CYCLES - 1);
  localparam logic [TmrW-1:0]    LowLast     = TmrW'(STEP_LOW - 1);
  localparam logic [TmrW-1:0]    GapLast     = TmrW'(STEP_GAP - 1);
  localparam logic [TmrW-1:0]    SettleLast  = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] MaxRetry    = RETRY_W'(MAX_RETRIES);

  pll_state_e          state_q, state_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [StableW-1:0]  stable_q, stable_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [PS_CNT_W-1:0] rem_q, rem_d;
  logic [1:0]          sel_q, sel_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                pll_rst_q, sys_rst_n_q, step_q, fault_q;
  logic                lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  assign ps_ready_o = (state_q == StRun) & lock_s;

  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    retry_d  = retry_q;
    loss_d   = loss_q;
    rem_d    = rem_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    unique case (state_q)
      StRstPll: if (tmr_q == RstLast) state_d = StWaitLock;
      StWaitLock: begin
        if (lock_s) stable_d = stable_q + 1'b1;
        // Qualification wins over a timeout landing on the same cycle.
        if (lock_s && (stable_q == StableLast)) begin
          state_d = StRun;
          retry_d = '0;
        end else if (tmr_q == TimeoutLast) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 1'b1;
            state_d = StRstPll;
          end else begin
            state_d = StFault;
          end
        end
      end
      StRun: begin
        if (ps_valid_i && ps_ready_o) begin
          sel_d = ps_sel_i;
          dir_d = ps_dir_i;
          if (ps_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = ps_count_i;
            state_d = StSetup;
          end
        end
      end
      StSetup: if (tmr_q == SetupLast) state_d = StPulse;
      StPulse: begin
        if (tmr_q == LowLast) begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == PS_CNT_W'(1)) ? StSettle : StGap;
        end
      end
      StGap: if (tmr_q == GapLast) state_d = StPulse;
      StSettle: begin
        if (tmr_q == SettleLast) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StRstPll;
    endcase

    // Lock loss overrides everything: drop back to WAIT_LOCK without resetting the PLL.
    if (is_active(state_q) && !lock_s) begin
      state_d  = StWaitLock;
      stable_d = '0;
      rem_d    = '0;
      done_d   = 1'b0;
      abort_d  = is_shift(state_q);
      if (loss_q != '1) loss_d = loss_q + 1'b1;
    end

    // Timer restarts on every state change and idles in untimed states.
    if ((state_d != state_q) || (state_q == StRun) || (state_q == StFault)) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRstPll;
      tmr_q       <= '0;
      stable_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      rem_q       <= '0;
      sel_q       <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      step_q      <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      stable_q    <= stable_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      rem_q       <= rem_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      // Registered outputs follow the state being entered, so they line up with state_q.
      pll_rst_q   <= (state_d == StRstPll) || (state_d == StFault);
      sys_rst_n_q <= is_active(state_q) && is_active(state_d);
      step_q      <= (state_d != StPulse);
      fault_q     <= fault_q || (state_d == StFault);
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign pll_phasesel_o  = sel_q;
  assign pll_phasedir_o  = dir_q;
  assign pll_phasestep_o = step_q;
  assign sys_rst_n_o     = sys_rst_n_q;
  assign ps_done_o       = done_q;
  assign ps_abort_o      = abort_q;
  assign fault_o         = fault_q;
  assign retry_cnt_o     = retry_q;
  assign loss_cnt_o      = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed self-checking bench for pll_supervisor with shortened timing parameters.
module tb_pll_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       sys_rst_n;
  logic       ps_valid;
  logic       ps_ready;
  logic [1:0] ps_sel;
  logic       ps_dir;
  logic [7:0] ps_count;
  logic       ps_done;
  logic       ps_abort;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pll_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_STABLE   (8),
    .LOCK_TIMEOUT  (50),
    .MAX_RETRIES   (2),
    .SETUP_CYCLES  (2),
    .STEP_LOW      (2),
    .STEP_GAP      (4),
    .SETTLE_CYCLES (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pll_locked_i    (pll_locked),
    .pll_rst_o       (pll_rst),
    .pll_phasesel_o  (pll_phasesel),
    .pll_phasedir_o  (pll_phasedir),
    .pll_phasestep_o (pll_phasestep),
    .sys_rst_n_o     (sys_rst_n),
    .ps_valid_i      (ps_valid),
    .ps_ready_o      (ps_ready),
    .ps_sel_i        (ps_sel),
    .ps_dir_i        (ps_dir),
    .ps_count_i      (ps_count),
    .ps_done_o       (ps_done),
    .ps_abort_o      (ps_abort),
    .fault_o         (fault),
    .retry_cnt_o     (retry_cnt),
    .loss_cnt_o      (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds reset for a few cycles, then releases it 1 time unit after a rising edge.
  task automatic do_reset(input logic lock_val);
    rst_n      = 1'b0;
    pll_locked = lock_val;
    ps_valid   = 1'b0;
    ps_sel     = 2'd0;
    ps_dir     = 1'b0;
    ps_count   = 8'd0;
    repeat (3) tick();
    tick();
    rst_n = 1'b1;
  endtask

  int          cnt;
  int          t_rise;
  int          falls;
  int          rises;
  int          fault_idx;
  int          abort_cnt;
  int          abort_idx;
  int          done_cnt;
  int          seldir_bad;
  logic        prev;
  logic [3:0]  r1, r2;
  logic [31:0] step_vec;
  logic [31:0] done_vec;

  initial begin
    // ---------------- Reset values ----------------
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    ps_valid   = 1'b0;
    ps_sel     = 2'd0;
    ps_dir     = 1'b0;
    ps_count   = 8'd0;
    repeat (2) tick();
    chk("rst_pll_rst",   32'(pll_rst), 32'd1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("rst_phasestep", 32'(pll_phasestep), 32'd1);
    chk("rst_phasesel",  32'(pll_phasesel), 32'd0);
    chk("rst_phasedir",  32'(pll_phasedir), 32'd0);
    chk("rst_done",      32'(ps_done), 32'd0);
    chk("rst_abort",     32'(ps_abort), 32'd0);
    chk("rst_fault",     32'(fault), 32'd0);
    chk("rst_retry",     32'(retry_cnt), 32'd0);
    chk("rst_loss",      32'(loss_cnt), 32'd0);
    chk("rst_ready",     32'(ps_ready), 32'd0);

    // ---------------- Lock 10 cycles after reset release ----------------
    do_reset(1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!pll_rst) break;
      cnt++;
      tick();
    end
    chk("pll_rst_width", 32'(cnt), 32'd4);
    repeat (6) tick();
    pll_locked = 1'b1;
    t_rise = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (sys_rst_n) begin
        t_rise = t;
        break;
      end
    end
    chk("sys_rst_rise_window", 32'((t_rise >= 10) && (t_rise <= 12)), 32'd1);
    chk("lock_retry_zero", 32'(retry_cnt), 32'd0);
    chk("run_ready", 32'(ps_ready), 32'd1);
    chk("run_pll_rst_low", 32'(pll_rst), 32'd0);

    // ---------------- Request sel=2 dir=1 count=3 ----------------
    ps_valid = 1'b1;
    ps_sel   = 2'd2;
    ps_dir   = 1'b1;
    ps_count = 8'd3;
    tick();
    ps_valid = 1'b0;
    ps_sel   = 2'd0;
    ps_dir   = 1'b0;
    chk("busy_not_ready", 32'(ps_ready), 32'd0);
    seldir_bad = 0;
    for (int j = 0; j < 32; j++) begin
      step_vec[j] = pll_phasestep;
      done_vec[j] = ps_done;
      if ((pll_phasesel != 2'd2) || (pll_phasedir != 1'b1)) seldir_bad++;
      tick();
    end
    // Pulses low at samples 2-3, 8-9, 14-15; done 5 cycles after last pulse ends (sample 16).
    chk("step_pattern", step_vec, 32'hFFFF_3CF3);
    chk("done_timing", done_vec, 32'h0020_0000);
    chk("seldir_stable", 32'(seldir_bad), 32'd0);

    // ---------------- Request count=0 ----------------
    ps_valid = 1'b1;
    ps_count = 8'd0;
    tick();
    ps_valid = 1'b0;
    chk("zero_done", 32'(ps_done), 32'd1);
    chk("zero_no_step", 32'(pll_phasestep), 32'd1);
    tick();
    chk("zero_done_pulse", 32'(ps_done), 32'd0);
    chk("zero_back_ready", 32'(ps_ready), 32'd1);
    chk("zero_no_step2", 32'(pll_phasestep), 32'd1);

    // ---------------- Lock loss during 2nd pulse of count=5 ----------------
    ps_valid = 1'b1;
    ps_sel   = 2'd1;
    ps_dir   = 1'b0;
    ps_count = 8'd5;
    tick();
    ps_valid = 1'b0;
    repeat (8) tick();
    chk("second_pulse_low", 32'(pll_phasestep), 32'd0);
    pll_locked = 1'b0;
    abort_cnt = 0;
    abort_idx = -1;
    done_cnt  = 0;
    for (int j = 9; j <= 20; j++) begin
      tick();
      if (ps_abort) begin
        abort_cnt++;
        abort_idx = j;
      end
      if (ps_done) done_cnt++;
    end
    chk("abort_once", 32'(abort_cnt), 32'd1);
    chk("abort_timing", 32'(abort_idx), 32'd11);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("loss_cnt", 32'(loss_cnt), 32'd1);
    chk("loss_sys_rst", 32'(sys_rst_n), 32'd0);
    chk("loss_step_high", 32'(pll_phasestep), 32'd1);
    chk("loss_no_pll_rst", 32'(pll_rst), 32'd0);
    chk("loss_not_ready", 32'(ps_ready), 32'd0);
    chk("loss_retry_kept", 32'(retry_cnt), 32'd0);

    // ---------------- Lock glitch at stable count 6 ----------------
    do_reset(1'b1);
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("glitch_not_early", 32'(sys_rst_n), 32'd0);
    repeat (6) tick();
    chk("glitch_still_held", 32'(sys_rst_n), 32'd0);
    tick();
    chk("glitch_released", 32'(sys_rst_n), 32'd1);

    // ---------------- Lock never asserted ----------------
    do_reset(1'b0);
    prev      = pll_rst;
    falls     = 0;
    rises     = 0;
    fault_idx = -1;
    r1        = 4'hF;
    r2        = 4'hF;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (prev && !pll_rst) falls++;
      if (!prev && pll_rst) begin
        rises++;
        if (rises == 1) r1 = retry_cnt;
        if (rises == 2) r2 = retry_cnt;
      end
      prev = pll_rst;
      if (fault) begin
        fault_idx = i;
        break;
      end
    end
    chk("nolock_pulses", 32'(falls), 32'd3);
    chk("nolock_retry1", 32'(r1), 32'd1);
    chk("nolock_retry2", 32'(r2), 32'd2);
    chk("nolock_fault_time", 32'(fault_idx), 32'd162);
    chk("fault_pll_rst", 32'(pll_rst), 32'd1);
    pll_locked = 1'b1;
    repeat (20) tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_pll_rst_held", 32'(pll_rst), 32'd1);
    chk("fault_sys_rst", 32'(sys_rst_n), 32'd0);
    chk("fault_not_ready", 32'(ps_ready), 32'd0);

    // ---------------- Asynchronous reset clears fault ----------------
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_fault_clr", 32'(fault), 32'd0);
    chk("async_retry_clr", 32'(retry_cnt), 32'd0);
    chk("async_pll_rst", 32'(pll_rst), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
